scan_test_ctrl: RTL and testbench

On-chip scan test sequencer for the EX_Core wrapper (4 parallel scan chains).
- Streams stimulus and expected data from a ready/valid source.
- Drives scan mode, the core clock enable and the scan inputs through a load / capture / unload sequence, with unload overlapped on the next load.
- Compares scan outputs against masked expected values and reports pass/fail, mismatch count and first failing pattern.
- Sits between the test access port/pattern buffer and EX_Core.

---
 rtl/scan_test_ctrl.sv | 141 ++++++++++++++
 tb/tb_scan_test_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: streams load/unload beats into parallel scan chains,
// inserts capture clocks between patterns and scores the unloaded responses.
module scan_test_ctrl #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 8,
  parameter int PAT_W      = 8,
  parameter int CAP_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PAT_W-1:0]      num_pat,
  input  logic                  stim_valid,
  output logic                  stim_ready,
  input  logic [NUM_CHAINS-1:0] stim_si,
  input  logic [NUM_CHAINS-1:0] stim_exp,
  input  logic [NUM_CHAINS-1:0] stim_mask,
  output logic [NUM_CHAINS-1:0] scan_in,
  input  logic [NUM_CHAINS-1:0] scan_out_core,
  output logic                  scan_mode,
  output logic                  core_clk_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           fail_cnt,
  output logic [PAT_W-1:0]      first_fail_pat
);
  localparam int BIT_W = (CHAIN_LEN  > 1) ? $clog2(CHAIN_LEN)  : 1;
  localparam int CAP_W = (CAP_CYCLES > 1) ? $clog2(CAP_CYCLES) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d, np_q, np_d, ffp_q, ffp_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CAP_W-1:0]  cap_q, cap_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              seen_q, seen_d;
  logic              mism;

  assign mism = |((scan_out_core ^ stim_exp) & stim_mask);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    np_d    = np_q;
    ffp_d   = ffp_q;
    bit_d   = bit_q;
    cap_d   = cap_q;
    fcnt_d  = fcnt_q;
    seen_d  = seen_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          np_d    = num_pat;
          pat_d   = '0;
          bit_d   = '0;
          cap_d   = '0;
          fcnt_d  = '0;
          ffp_d   = '0;
          seen_d  = 1'b0;
          state_d = (num_pat == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (stim_valid) begin
          // pass 0 unloads whatever the core held before the session
          if (pat_q != '0 && mism) begin
            if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
            if (!seen_q) begin
              seen_d = 1'b1;
              ffp_d  = pat_q - PAT_W'(1);
            end
          end
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            cap_d   = '0;
            state_d = (pat_q == np_q) ? S_DONE : S_CAP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_CAP: begin
        if (cap_q == CAP_LAST) begin
          cap_d   = '0;
          pat_d   = pat_q + PAT_W'(1);
          state_d = S_SHIFT;
        end else begin
          cap_d = cap_q + CAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // abort discards the beat on its edge; results so far are kept
    if (abort) begin
      state_d = S_IDLE;
      pat_d   = '0;
      bit_d   = '0;
      cap_d   = '0;
      fcnt_d  = fcnt_q;
      ffp_d   = ffp_q;
      seen_d  = seen_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      np_q    <= '0;
      ffp_q   <= '0;
      bit_q   <= '0;
      cap_q   <= '0;
      fcnt_q  <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      np_q    <= np_d;
      ffp_q   <= ffp_d;
      bit_q   <= bit_d;
      cap_q   <= cap_d;
      fcnt_q  <= fcnt_d;
      seen_q  <= seen_d;
    end
  end

  assign stim_ready     = (state_q == S_SHIFT);
  assign scan_mode      = (state_q == S_SHIFT);
  assign scan_in        = (state_q == S_SHIFT) ? stim_si : '0;
  assign core_clk_en    = ((state_q == S_SHIFT) && stim_valid) || (state_q == S_CAP);
  assign busy           = (state_q == S_SHIFT) || (state_q == S_CAP);
  assign done           = (state_q == S_DONE);
  assign pass           = (state_q == S_DONE) && (fcnt_q == 16'd0);
  assign fail_cnt       = fcnt_q;
  assign first_fail_pat = ffp_q;
endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: a behavioural core (shift chains, capture = invert)
// plus table-driven sessions and hand sequences for abort/reset.
module tb_scan_test_ctrl;
  localparam int NC = 4, CL = 8, PW = 8;

  logic          CLK = 1'b0;
  logic          resetn, start, abort, stim_valid;
  logic [PW-1:0] num_pat;
  logic [NC-1:0] stim_si, stim_exp, stim_mask, scan_in, scan_out_core;
  logic          stim_ready, scan_mode, core_clk_en, busy, done, pass;
  logic [15:0]   fail_cnt;
  logic [PW-1:0] first_fail_pat;

  scan_test_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .PAT_W(PW), .CAP_CYCLES(1)) dut (
    .CLK(CLK), .resetn(resetn), .start(start), .abort(abort), .num_pat(num_pat),
    .stim_valid(stim_valid), .stim_ready(stim_ready), .stim_si(stim_si),
    .stim_exp(stim_exp), .stim_mask(stim_mask), .scan_in(scan_in),
    .scan_out_core(scan_out_core), .scan_mode(scan_mode), .core_clk_en(core_clk_en),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail_pat(first_fail_pat));

  always #5 CLK = ~CLK;

  // core model: flop 0 takes scan_in, flop CL-1 drives scan_out; capture inverts
  logic [NC-1:0] core [CL];
  assign scan_out_core = core[CL-1];
  always @(posedge CLK) begin
    if (core_clk_en) begin
      if (scan_mode) begin
        core[0] <= scan_in;
        for (int j = 1; j < CL; j++) core[j] <= core[j-1];
      end else begin
        for (int j = 0; j < CL; j++) core[j] <= ~core[j];
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] si_f(input int p, input int b);
    return NC'((p * 7 + b * 3 + 1) ^ (b << 1));
  endfunction

  typedef struct {
    int np; int err; int gap_lo; int gap_hi; int busy_start;
    int exp_done; int exp_fail; int exp_first; int exp_pass;
    int exp_beats; int exp_caps; int exp_cap1;
  } vec_t;

  int r_done, r_beats, r_caps, r_cap1, r_viol;

  // err: 1 flip chain 2 on pass1 beat3, 2 same but masked, 3 flip all compared beats,
  //      4 flip pass2 beat0 and pass3 beat5
  task automatic run_sess(input int np, input int err, input int gap_lo, input int gap_hi,
                          input int busy_start, input int stop_cyc, input bit stop_rst);
    int beats, p, b;
    logic [NC-1:0] e, m;
    r_done = -1; r_beats = 0; r_caps = 0; r_cap1 = -1; r_viol = 0;
    beats = 0;
    num_pat = PW'(np);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge CLK);
      if (stop_cyc >= 0 && cyc == stop_cyc + 1) break;
      if (cyc > 0 && done && stop_cyc < 0) begin r_done = cyc; break; end
      if (busy && !scan_mode) begin
        r_caps++;
        if (r_cap1 < 0) r_cap1 = cyc;
      end
      start  = (cyc == 0) || (cyc == busy_start);
      abort  = (cyc == stop_cyc) && !stop_rst;
      resetn = !((cyc == stop_cyc) && stop_rst);
      stim_valid = !(cyc >= gap_lo && cyc <= gap_hi);
      p = beats / CL; b = beats % CL;
      stim_si = si_f(p, b);
      e = (p == 0) ? (si_f(p, b) ^ 4'hA) : ~si_f(p - 1, b);
      m = '1;
      if ((err == 1 || err == 2) && p == 1 && b == 3) e[2] = ~e[2];
      if (err == 2 && p == 1 && b == 3) m[2] = 1'b0;
      if (err == 3 && p >= 1) e = ~e;
      if (err == 4 && ((p == 2 && b == 0) || (p == 3 && b == 5))) e = ~e;
      stim_exp = e; stim_mask = m;
      #1;
      if (stim_ready) begin
        if (scan_in !== stim_si || core_clk_en !== stim_valid) r_viol++;
        if (stim_valid) beats++;
      end else if (busy) begin
        if (scan_in !== '0 || core_clk_en !== 1'b1 || scan_mode !== 1'b0) r_viol++;
      end else begin
        if (scan_in !== '0 || core_clk_en !== 1'b0) r_viol++;
      end
    end
    r_beats = beats;
    start = 1'b0; abort = 1'b0; resetn = 1'b1; stim_valid = 1'b0;
  endtask

  vec_t vt [8];

  task automatic run_vec(input int i);
    run_sess(vt[i].np, vt[i].err, vt[i].gap_lo, vt[i].gap_hi, vt[i].busy_start, -1, 1'b0);
    chk($sformatf("v%0d done_cycle", i), r_done, vt[i].exp_done);
    chk($sformatf("v%0d beats", i), r_beats, vt[i].exp_beats);
    chk($sformatf("v%0d captures", i), r_caps, vt[i].exp_caps);
    chk($sformatf("v%0d first_capture_cycle", i), r_cap1, vt[i].exp_cap1);
    chk($sformatf("v%0d per_cycle_violations", i), r_viol, 0);
    chk($sformatf("v%0d fail_cnt", i), fail_cnt, vt[i].exp_fail);
    chk($sformatf("v%0d first_fail_pat", i), first_fail_pat, vt[i].exp_first);
    chk($sformatf("v%0d pass", i), pass, vt[i].exp_pass);
    chk($sformatf("v%0d idle_outputs", i), {busy, scan_mode, stim_ready, core_clk_en}, 0);
    @(negedge CLK);
    chk($sformatf("v%0d done_held", i), {done, pass}, {1'b1, 1'(vt[i].exp_pass)});
  endtask

  initial begin
    //        np err glo ghi bs  done fail first pass beats caps cap1
    vt[0] = '{2, 0, -1, -1, -1, 27, 0,  0, 1, 24, 2, 9};
    vt[1] = '{2, 1, -1, -1, -1, 27, 1,  0, 0, 24, 2, 9};
    vt[2] = '{2, 2, -1, -1, -1, 27, 0,  0, 1, 24, 2, 9};
    vt[3] = '{2, 0,  5,  7, -1, 30, 0,  0, 1, 24, 2, 12};
    vt[4] = '{0, 0, -1, -1, -1, 1,  0,  0, 1, 0,  0, -1};
    vt[5] = '{2, 3, -1, -1, 12, 27, 16, 0, 0, 24, 2, 9};
    vt[6] = '{1, 1, -1, -1, -1, 18, 1,  0, 0, 16, 1, 9};
    vt[7] = '{3, 4, -1, -1, -1, 36, 2,  1, 0, 32, 3, 9};

    for (int j = 0; j < CL; j++) core[j] = '0;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; stim_valid = 1'b0;
    num_pat = '0; stim_si = '0; stim_exp = '0; stim_mask = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {stim_ready, scan_in, scan_mode, core_clk_en, busy, done, pass,
                          fail_cnt, first_fail_pat}, 0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // abort in the first capture cycle
    run_sess(2, 0, -1, -1, -1, 9, 1'b0);
    chk("abort_cap_outputs", {scan_mode, core_clk_en, busy, done, stim_ready}, 0);
    chk("abort_cap_captures", r_caps, 1);

    // abort mid pass 1 of a failing session: results so far are held
    run_sess(2, 3, -1, -1, -1, 14, 1'b0);
    chk("abort_hold_fail_cnt", fail_cnt, 4);
    chk("abort_hold_first_fail", first_fail_pat, 0);
    chk("abort_hold_flags", {busy, done, pass, scan_mode}, 0);

    // start together with abort in IDLE: abort wins
    @(negedge CLK);
    num_pat = 8'd2; start = 1'b1; abort = 1'b1;
    @(negedge CLK);
    chk("abort_beats_start", {busy, done, stim_ready}, 0);
    start = 1'b0; abort = 1'b0;

    // reset mid-shift with a nonzero fail count clears everything
    run_sess(2, 3, -1, -1, -1, 13, 1'b1);
    chk("reset_mid_shift_outputs", {stim_ready, scan_in, scan_mode, core_clk_en, busy, done,
                                    pass, fail_cnt, first_fail_pat}, 0);

    // a fresh session after abort/reset runs cleanly
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
